e_mdu_ctrl: RTL and testbench
=============================

// Module: e_mdu_ctrl
// PURPOSE
//   E-stage multiply/divide sequencer for the P6 pipeline. Accepts one MD op per cycle
//   from the E stage, models multi-cycle latency with a busy counter, owns the HI/LO
//   registers, and raises the D-stage stall when a new MD instruction must wait.
//   Sits beside the E-stage ALU; operands arrive already forwarded.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//   DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//   in_clk        in   1   clock; all state updates on rising edge
//   in_reset      in   1   synchronous active-high reset
//   in_mdu_op     in   4   E-stage op: 0 none,1 mult,2 multu,3 div,4 divu,5 mfhi,6 mflo,7 mthi,8 mtlo; 9-15 = none
//   in_num1       in   32  rs operand (forwarded)
//   in_num2       in   32  rt operand (forwarded)
//   in_d_is_md    in   1   D-stage instruction is any MD op (1-8)
//   out_start     out  1   comb: op in {1..4} and not busy
//   out_busy      out  1   registered: multi-cycle op in flight
//   out_stall     out  1   comb: in_d_is_md & (out_start | out_busy)
//   out_result    out  32  comb: HI for op 5, LO for op 6, else 0
// BEHAVIOUR
//   Reset: HI=0, LO=0, counter=0, state IDLE, pending regs=0; out_busy=0, out_start=0 (op=0).
//   FSM IDLE/BUSY. IDLE: op 1-4 at edge -> load counter with MULT_/DIV_CYCLES, compute result
//     from in_num1/in_num2 into pend_hi/pend_lo, go BUSY. Op 7/8 -> HI/LO <= in_num1 at edge.
//   BUSY: counter decrements each edge; on edge where counter==1: HI<=pend_hi, LO<=pend_lo,
//     counter<=0, go IDLE. out_busy = (state==BUSY).
//   Latency: op issued in cycle T -> out_busy high cycles T+1..T+N; new HI/LO readable T+N+1.
//   Arithmetic: mult signed 64-bit {HI,LO}=$signed*$signed; multu unsigned;
//     div: LO=signed quotient, HI=signed remainder (sign of dividend, trunc toward 0);
//     divu unsigned. Divisor==0: pending = current HI/LO (HI/LO unchanged) but full busy time.
//     Signed 0x80000000 / -1: LO=0x80000000, HI=0.
//   mfhi/mflo read the committed HI/LO (never pend_*); under correct stall use they are never
//     issued while busy. Any op 1-8 arriving while BUSY is ignored (no state change, out_start=0).
//   Simultaneous: last busy edge and op 1-4 cannot coexist (stall); mthi in same cycle as
//     in_reset -> reset wins.
//   Reset mid-operation: in-flight result discarded, HI/LO=0, IDLE next cycle.
//   out_stall does not depend on in_mdu_op values 9-15 (treated as none).
// TESTING
//   reset; mthi 0x1234, mtlo 0x5678; mfhi/mflo -> out_result 0x1234 then 0x5678, busy never set.
//   mult 0xFFFFFFFF*2 -> busy 5 cycles; HI=0xFFFFFFFF LO=0xFFFFFFFE; multu same -> HI=1 LO=0xFFFFFFFE.
//   div -7/2 -> busy 10 cycles; LO=0xFFFFFFFD HI=0xFFFFFFFF; divu 7/0 -> HI/LO unchanged after 10.
//   mult issued, in_d_is_md=1 every cycle -> out_stall high cycle T and T+1..T+5, low at T+6.
//   in_reset asserted at busy cycle 3 of div -> next cycle busy=0, HI=LO=0, no late writeback.
//   mthi while BUSY (forced) -> HI unchanged; op 12 -> out_start=0, out_stall=0 when idle.

Source files
------------

// File: rtl/e_mdu_ctrl.sv
// rtl/e_mdu_ctrl.sv - E-stage multiply/divide sequencer owning HI/LO with busy counter and D-stage stall
module e_mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        in_clk,
    input  logic        in_reset,
    input  logic [3:0]  in_mdu_op,
    input  logic [31:0] in_num1,
    input  logic [31:0] in_num2,
    input  logic        in_d_is_md,
    output logic        out_start,
    output logic        out_busy,
    output logic        out_stall,
    output logic [31:0] out_result
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [CW-1:0] counter;
    logic [31:0]   hi, lo, pend_hi, pend_lo;
    logic [31:0]   next_hi, next_lo;
    logic [63:0]   prod_s, prod_u;
    logic [31:0]   abs1, abs2, quot_a, rem_a, quot_s, rem_s, quot_u, rem_u;
    logic          is_long, div_zero;

    assign is_long   = (in_mdu_op >= OP_MULT) && (in_mdu_op <= OP_DIVU);
    assign out_busy  = (state == BUSY);
    assign out_start = is_long && (state == IDLE);
    assign out_stall = in_d_is_md && (out_start || out_busy);
    assign div_zero  = (in_num2 == 32'd0);

    assign prod_s = $signed({{32{in_num1[31]}}, in_num1}) * $signed({{32{in_num2[31]}}, in_num2});
    assign prod_u = {32'd0, in_num1} * {32'd0, in_num2};

    // Signed divide through magnitudes so 0x80000000 / -1 wraps to 0x80000000 rem 0
    assign abs1 = in_num1[31] ? (~in_num1 + 32'd1) : in_num1;
    assign abs2 = in_num2[31] ? (~in_num2 + 32'd1) : in_num2;

    always_comb begin
        quot_a = 32'd0;
        rem_a  = 32'd0;
        quot_u = 32'd0;
        rem_u  = 32'd0;
        if (!div_zero) begin
            quot_a = abs1 / abs2;
            rem_a  = abs1 % abs2;
            quot_u = in_num1 / in_num2;
            rem_u  = in_num1 % in_num2;
        end
        quot_s = (in_num1[31] ^ in_num2[31]) ? (~quot_a + 32'd1) : quot_a;
        rem_s  = in_num1[31] ? (~rem_a + 32'd1) : rem_a;
    end

    always_comb begin
        next_hi = hi;
        next_lo = lo;
        case (in_mdu_op)
            OP_MULT:  begin next_hi = prod_s[63:32]; next_lo = prod_s[31:0]; end
            OP_MULTU: begin next_hi = prod_u[63:32]; next_lo = prod_u[31:0]; end
            OP_DIV:   if (!div_zero) begin next_hi = rem_s; next_lo = quot_s; end
            OP_DIVU:  if (!div_zero) begin next_hi = rem_u; next_lo = quot_u; end
            default:  ;
        endcase
    end

    always_comb begin
        out_result = 32'd0;
        if (in_mdu_op == OP_MFHI)      out_result = hi;
        else if (in_mdu_op == OP_MFLO) out_result = lo;
    end

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state   <= IDLE;
            counter <= '0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_long) begin
                        counter <= (in_mdu_op <= OP_MULTU) ? MULT_LOAD : DIV_LOAD;
                        pend_hi <= next_hi;
                        pend_lo <= next_lo;
                        state   <= BUSY;
                    end else if (in_mdu_op == OP_MTHI) begin
                        hi <= in_num1;
                    end else if (in_mdu_op == OP_MTLO) begin
                        lo <= in_num1;
                    end
                end
                BUSY: begin
                    // Any MD op arriving here is dropped; only the counter advances
                    if (counter == CNT_ONE) begin
                        hi      <= pend_hi;
                        lo      <= pend_lo;
                        counter <= '0;
                        state   <= IDLE;
                    end else begin
                        counter <= counter - CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// tb/tb_e_mdu_ctrl.sv - directed table and sequence bench for e_mdu_ctrl
module tb_e_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  op;
    logic [31:0] num1, num2;
    logic        d_is_md;
    logic        start, busy, stall;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    e_mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .in_clk     (clk),
        .in_reset   (reset),
        .in_mdu_op  (op),
        .in_num1    (num1),
        .in_num2    (num2),
        .in_d_is_md (d_is_md),
        .out_start  (start),
        .out_busy   (busy),
        .out_stall  (stall),
        .out_result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic        d_is_md;
        logic        exp_start;
        logic        exp_stall;
        logic [31:0] exp_result;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive op for exactly one rising edge, return 1ns after that edge with op cleared
    task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o; num1 = a; num2 = b;
        @(posedge clk); #1;
        op = 4'd0;
    endtask

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        logic [3:0] saved;
        saved = op;
        op = 4'd5; #1; h = result;
        op = 4'd6; #1; l = result;
        op = saved; #1;
    endtask

    task automatic run_md(input string name, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cycles,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cnt;
        logic [31:0] h, l;
        do_op(o, a, b);
        cnt = 0;
        while (busy && cnt < 50) begin
            cnt++;
            @(posedge clk); #1;
        end
        check({name, " busy_cycles"}, cnt, exp_cycles);
        read_hilo(h, l);
        check({name, " hi"}, h, exp_hi);
        check({name, " lo"}, l, exp_lo);
    endtask

    initial begin
        logic [31:0] h, l;

        vecs[0]  = '{4'd5,  1'b0, 1'b0, 1'b0, 32'h0000_1234};
        vecs[1]  = '{4'd6,  1'b1, 1'b0, 1'b0, 32'h0000_5678};
        vecs[2]  = '{4'd1,  1'b1, 1'b1, 1'b1, 32'h0};
        vecs[3]  = '{4'd2,  1'b0, 1'b1, 1'b0, 32'h0};
        vecs[4]  = '{4'd3,  1'b1, 1'b1, 1'b1, 32'h0};
        vecs[5]  = '{4'd4,  1'b0, 1'b1, 1'b0, 32'h0};
        vecs[6]  = '{4'd0,  1'b1, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{4'd12, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{4'd15, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{4'd7,  1'b1, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{4'd9,  1'b0, 1'b0, 1'b0, 32'h0};

        reset = 1'b1; op = 4'd0; num1 = 32'd0; num2 = 32'd0; d_is_md = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset start", {31'd0, start}, 32'd0);
        read_hilo(h, l);
        check("reset hi", h, 32'd0);
        check("reset lo", l, 32'd0);

        do_op(4'd7, 32'h0000_1234, 32'd0);
        check("mthi busy", {31'd0, busy}, 32'd0);
        do_op(4'd8, 32'h0000_5678, 32'd0);
        check("mtlo busy", {31'd0, busy}, 32'd0);

        // Combinational checks only: every vector is withdrawn before the next rising edge
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            op = vecs[i].op; d_is_md = vecs[i].d_is_md;
            num1 = 32'hDEAD_BEEF; num2 = 32'h3;
            #1;
            check($sformatf("vec%0d start", i), {31'd0, start}, {31'd0, vecs[i].exp_start});
            check($sformatf("vec%0d stall", i), {31'd0, stall}, {31'd0, vecs[i].exp_stall});
            check($sformatf("vec%0d result", i), result, vecs[i].exp_result);
            check($sformatf("vec%0d busy", i), {31'd0, busy}, 32'd0);
            #1;
            op = 4'd0; d_is_md = 1'b0;
        end

        run_md("mult",  4'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_md("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
        run_md("div",   4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("divu0", 4'd4, 32'd7, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);
        run_md("divneg", 4'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
        run_md("divu",  4'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);

        // Stall window around a mult with a D-stage MD op waiting every cycle
        @(negedge clk);
        d_is_md = 1'b1; op = 4'd1; num1 = 32'd3; num2 = 32'd4;
        #1;
        check("stall T", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        op = 4'd0;
        for (int k = 1; k <= 5; k++) begin
            #1;
            check($sformatf("stall T+%0d", k), {31'd0, stall}, 32'd1);
            @(posedge clk); #1;
        end
        #1;
        check("stall T+6", {31'd0, stall}, 32'd0);
        d_is_md = 1'b0;

        // Reset during busy cycle 3 of a div must discard the pending result
        do_op(4'd3, 32'd100, 32'd7);
        repeat (2) @(posedge clk);
        #1;
        check("rst mid busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst mid busy after", {31'd0, busy}, 32'd0);
        read_hilo(h, l);
        check("rst mid hi", h, 32'd0);
        check("rst mid lo", l, 32'd0);
        repeat (12) @(posedge clk);
        #1;
        read_hilo(h, l);
        check("rst no late hi", h, 32'd0);
        check("rst no late lo", l, 32'd0);

        // mthi forced while busy is ignored; the mult result still lands
        do_op(4'd7, 32'h0000_0011, 32'd0);
        do_op(4'd1, 32'd3, 32'd4);
        @(negedge clk);
        op = 4'd7; num1 = 32'h0000_DEAD;
        #1;
        check("mthi busy start", {31'd0, start}, 32'd0);
        @(posedge clk); #1;
        op = 4'd0;
        read_hilo(h, l);
        check("mthi busy hi", h, 32'h0000_0011);
        repeat (5) @(posedge clk);
        #1;
        check("mthi busy done", {31'd0, busy}, 32'd0);
        read_hilo(h, l);
        check("mult after mthi hi", h, 32'd0);
        check("mult after mthi lo", l, 32'd12);

        // mthi coinciding with reset loses to reset
        do_op(4'd7, 32'h0000_0999, 32'd0);
        @(negedge clk);
        op = 4'd7; num1 = 32'h0000_0777; reset = 1'b1;
        @(posedge clk); #1;
        op = 4'd0; reset = 1'b0;
        read_hilo(h, l);
        check("mthi vs reset hi", h, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
